otter_fetch_queue: RTL and testbench

//  Parametrised N-entry instruction queue between the fetch stage and the decode stage of the pipelined OTTER.

---
 rtl/otter_pipe_pkg.sv | 12 +
 rtl/otter_fetch_queue.sv | 84 ++++++++
 tb/tb_otter_fetch_queue.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for the OTTER pipeline stages.
package otter_pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] OTTER_NOP = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } fetch_pkt_t;

endpackage

// File: rtl/otter_fetch_queue.sv
// IF->DE instruction queue: DEPTH-entry circular buffer of {pc, ir} pairs with
// valid/ready on both sides and a one-cycle flush on redirect.
module otter_fetch_queue
    import otter_pipe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     IF_VALID,
    input  logic [XLEN-1:0]          IF_PC,
    input  logic [XLEN-1:0]          IF_IR,
    output logic                     IF_READY,
    output logic                     DE_VALID,
    output logic [XLEN-1:0]          DE_PC,
    output logic [XLEN-1:0]          DE_IR,
    input  logic                     DE_READY,
    input  logic                     FLUSH,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    fetch_pkt_t       storage_reg [DEPTH];
    fetch_pkt_t       head_pkt;
    logic             push;
    logic             pop;

    assign IF_READY = !RESET && (count_reg < CNT_W'(DEPTH));
    assign DE_VALID = (count_reg != '0);
    assign COUNT    = count_reg;

    assign push = IF_VALID && IF_READY && !FLUSH;
    assign pop  = DE_VALID && DE_READY && !FLUSH;

    // Empty queue shows a bubble rather than whatever the head slot last held.
    assign head_pkt = storage_reg[rd_ptr_reg];
    assign DE_PC    = DE_VALID ? head_pkt.pc : '0;
    assign DE_IR    = DE_VALID ? head_pkt.ir : OTTER_NOP;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (FLUSH) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            if (push && !pop)      count_next = count_reg + CNT_W'(1);
            else if (pop && !push) count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Payload slots carry no reset: validity is tracked by count alone.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge CLK) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    storage_reg[gi] <= '{pc: IF_PC, ir: IF_IR};
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Bench for otter_fetch_queue: directed vectors on DEPTH=4, then random
// traffic on DEPTH=2/4/8 against a queue-based reference model.
module tb_otter_fetch_queue;
    import otter_pipe_pkg::*;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst, flush, if_valid, de_ready;
    logic [31:0] if_pc, if_ir;

    logic        rdy_w [NI];
    logic        val_w [NI];
    logic [31:0] pc_w  [NI];
    logic [31:0] ir_w  [NI];
    logic [3:0]  cnt_w [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int D = (gi == 0) ? 2 : (gi == 1) ? 4 : 8;
            logic [$clog2(D):0] cnt;
            otter_fetch_queue #(.DEPTH(D)) dut (
                .CLK      (clk),
                .RESET    (rst),
                .IF_VALID (if_valid),
                .IF_PC    (if_pc),
                .IF_IR    (if_ir),
                .IF_READY (rdy_w[gi]),
                .DE_VALID (val_w[gi]),
                .DE_PC    (pc_w[gi]),
                .DE_IR    (ir_w[gi]),
                .DE_READY (de_ready),
                .FLUSH    (flush),
                .COUNT    (cnt)
            );
            assign cnt_w[gi] = 4'(cnt);
        end
    endgenerate

    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD0003;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic v,
                         input logic [31:0] pc, input logic dr);
        @(negedge clk);
        rst = r; flush = f; if_valid = v; if_pc = pc; if_ir = ir_of(pc); de_ready = dr;
        #1;
    endtask

    task automatic chk_out(input int i, input string tag, input logic [3:0] cnt,
                           input logic rdy, input logic val, input logic [31:0] dpc,
                           input logic [31:0] dir);
        chk({tag, " count"},    32'(cnt_w[i]), 32'(cnt));
        chk({tag, " if_ready"}, 32'(rdy_w[i]), 32'(rdy));
        chk({tag, " de_valid"}, 32'(val_w[i]), 32'(val));
        chk({tag, " de_pc"},    pc_w[i], dpc);
        chk({tag, " de_ir"},    ir_w[i], dir);
    endtask

    typedef struct {
        logic        rst, flush, v;
        logic [31:0] pc;
        logic        dr;
        logic [3:0]  cnt;
        logic        rdy, val;
        logic [31:0] dpc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic f, input logic v,
                                input logic [31:0] pc, input logic dr, input int cnt,
                                input logic rdy, input logic val, input logic [31:0] dpc);
        vec_t t;
        t.rst = r; t.flush = f; t.v = v; t.pc = pc; t.dr = dr;
        t.cnt = 4'(cnt); t.rdy = rdy; t.val = val; t.dpc = dpc;
        return t;
    endfunction

    vec_t       tbl [19];
    fetch_pkt_t mq [NI][$];
    int         depths [NI] = '{2, 4, 8};

    initial begin
        logic [31:0] pcn;
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; de_ready = 1'b0;
        if_pc = '0; if_ir = '0;

        // Outputs listed are those seen during the cycle, before its edge.
        tbl[0]  = mk(1,0,0,32'h00,0, 0,0,0,32'h00);
        tbl[1]  = mk(0,0,1,32'h00,0, 0,1,0,32'h00);
        tbl[2]  = mk(0,0,1,32'h04,0, 1,1,1,32'h00);
        tbl[3]  = mk(0,0,1,32'h08,0, 2,1,1,32'h00);
        tbl[4]  = mk(0,0,1,32'h0C,0, 3,1,1,32'h00);
        tbl[5]  = mk(0,0,1,32'h10,0, 4,0,1,32'h00);
        tbl[6]  = mk(0,0,1,32'h10,0, 4,0,1,32'h00);
        tbl[7]  = mk(0,0,1,32'h10,1, 4,0,1,32'h00);
        tbl[8]  = mk(0,0,1,32'h10,0, 3,1,1,32'h04);
        tbl[9]  = mk(0,0,0,32'h00,0, 4,0,1,32'h04);
        tbl[10] = mk(0,0,0,32'h00,1, 4,0,1,32'h04);
        tbl[11] = mk(0,1,1,32'h40,1, 3,1,1,32'h08);
        tbl[12] = mk(0,0,0,32'h00,0, 0,1,0,32'h00);
        tbl[13] = mk(0,0,0,32'h00,1, 0,1,0,32'h00);
        tbl[14] = mk(0,0,1,32'h50,0, 0,1,0,32'h00);
        tbl[15] = mk(0,0,1,32'h54,0, 1,1,1,32'h50);
        tbl[16] = mk(1,0,1,32'h58,1, 2,0,1,32'h50);
        tbl[17] = mk(0,0,0,32'h00,0, 0,1,0,32'h00);
        tbl[18] = mk(0,0,0,32'h00,0, 0,1,0,32'h00);

        repeat (2) @(posedge clk);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].flush, tbl[i].v, tbl[i].pc, tbl[i].dr);
            $display("vec %0d: rst=%0b flush=%0b v=%0b pc=%h dr=%0b -> count=%0d rdy=%0b val=%0b de_pc=%h",
                     i, rst, flush, if_valid, if_pc, de_ready, cnt_w[1], rdy_w[1], val_w[1], pc_w[1]);
            chk_out(1, $sformatf("vec%0d", i), tbl[i].cnt, tbl[i].rdy, tbl[i].val, tbl[i].dpc,
                    tbl[i].val ? ir_of(tbl[i].dpc) : OTTER_NOP);
        end

        // Steady stream from empty: occupancy settles at 1, head advances by 4.
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 1, 32'h100 + 32'(4 * k), 1);
            $display("stream %0d: pc=%h count=%0d de_pc=%h", k, if_pc, cnt_w[1], pc_w[1]);
            if (k == 0) chk_out(1, "stream0", 0, 1, 0, 32'h0, OTTER_NOP);
            else begin
                pcn = 32'h100 + 32'(4 * (k - 1));
                chk_out(1, $sformatf("stream%0d", k), 1, 1, 1, pcn, ir_of(pcn));
            end
        end
        drive(0, 0, 0, 32'h0, 1);
        pcn = 32'h100 + 32'(4 * 19);
        chk_out(1, "stream_tail", 1, 1, 1, pcn, ir_of(pcn));
        drive(0, 0, 0, 32'h0, 1);
        chk_out(1, "stream_drained", 0, 1, 0, 32'h0, OTTER_NOP);

        // Random phase on all depths; an unchecked reset cycle aligns DUTs and model.
        drive(1, 0, 0, 32'h0, 0);
        @(posedge clk);
        for (int i = 0; i < NI; i++) mq[i].delete();
        pcn = 32'h1000;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            rst      = ($urandom_range(199) == 0);
            flush    = ($urandom_range(29) == 0);
            if_valid = ($urandom_range(9) < 7);
            de_ready = ($urandom_range(9) < 6);
            if_pc    = pcn;
            if_ir    = $urandom;
            pcn      = pcn + 32'h4;
            #1;
            for (int i = 0; i < NI; i++) begin
                logic        e_val, e_rdy, do_push, do_pop;
                logic [31:0] e_pc, e_ir;
                fetch_pkt_t  pk;
                e_val = (mq[i].size() != 0);
                e_rdy = !rst && (mq[i].size() < depths[i]);
                e_pc  = e_val ? mq[i][0].pc : 32'h0;
                e_ir  = e_val ? mq[i][0].ir : OTTER_NOP;
                chk_out(i, $sformatf("rand d%0d c%0d", depths[i], c),
                        4'(mq[i].size()), e_rdy, e_val, e_pc, e_ir);
                do_push = if_valid && e_rdy && !flush;
                do_pop  = e_val && de_ready && !flush;
                if (rst || flush) mq[i].delete();
                else begin
                    if (do_pop) void'(mq[i].pop_front());
                    if (do_push) begin
                        pk.pc = if_pc; pk.ir = if_ir;
                        mq[i].push_back(pk);
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
